imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/le_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES           = 2;
  localparam int unsigned BYTES_PER_WORD      = 4;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

endpackage

// File: rtl/le_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid on the 4th byte.
module le_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] lanes_q, lanes_d;

  always_comb begin
    cnt_d      = cnt_q;
    lanes_d    = lanes_q;
    word_out   = lanes_q;
    word_valid = 1'b0;
    if (byte_en) begin
      case (cnt_q)
        2'd0:    word_out[7:0]   = byte_in;
        2'd1:    word_out[15:8]  = byte_in;
        2'd2:    word_out[23:16] = byte_in;
        default: word_out[31:24] = byte_in;
      endcase
      lanes_d    = word_out;
      cnt_d      = cnt_q + 2'd1;
      word_valid = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header parse, word writes to instruction memory, core hold.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e FINAL_ST = CSUM;
`else
  localparam state_e FINAL_ST = DONE;
`endif

  state_e            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic        byte_en;
  logic        word_valid;
  logic [31:0] packed_word;
  logic [15:0] n_hdr;

  assign rx_ready  = !reset && (state_q inside {HDR0, HDR1, DATA, CSUM});
  assign accept    = rx_valid && rx_ready;
  assign byte_en   = accept && (state_q == DATA);
  assign n_hdr     = {rx_data, cnt_lo_q};
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);
  assign core_hold = ~done;

  le_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (rx_data),
    .byte_en    (byte_en),
    .word_valid (word_valid),
    .word_out   (packed_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    n_d         = n_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (byte_en) csum_d = csum_q ^ rx_data;
`endif
    case (state_q)
      HDR0: if (accept) begin
        cnt_lo_d = rx_data;
        state_d  = HDR1;
      end
      HDR1: if (accept) begin
        n_d = n_hdr;
        if ({1'b0, n_hdr} > DEPTH_LIM) state_d = ERR;
        else if (n_hdr == 16'd0)       state_d = FINAL_ST;
        else                           state_d = DATA;
      end
      DATA: if (word_valid) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = idx_q[ADDR_W-1:0];
        mem_wdata_d = packed_word;
        idx_d       = idx_q + (ADDR_W+1)'(1);
        // idx_q is one bit wider than the address so N = DEPTH_WORDS ends cleanly
        if (32'(idx_q) + 32'd1 == 32'(n_q)) state_d = FINAL_ST;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (accept) state_d = (rx_data == csum_q) ? DONE : ERR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR0;
      cnt_lo_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; expected writes derived from the stream format.
module tb_imem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0]  pay[$];
  int unsigned exp_a[$];
  logic [31:0] exp_d[$];
  int unsigned obs_a[$];
  logic [31:0] obs_d[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_a.push_back(int'(mem_addr));
      obs_d.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input bit full);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    if (full) begin
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_hold", 32'(core_hold), 32'd1);
    end
    reset = 1'b0;
    obs_a.delete();
    obs_d.delete();
    @(negedge clk);
    if (full) check("post_rst_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic run_image(input string tag, input int unsigned n, input int unsigned gmax,
                           input bit rnd, input bit csum_ok);
    logic [7:0]  x;
    logic [15:0] n16;
    int unsigned bad;
    bit          exp_done;
    x = '0;
    n16 = 16'(n);
    exp_a.delete();
    exp_d.delete();
    if (n <= DEPTH) begin
      for (int unsigned i = 0; i < n; i++) begin
        exp_a.push_back(i);
        exp_d.push_back({pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]});
      end
      for (int unsigned i = 0; i < 4*n; i++) x ^= pay[i];
    end
    exp_done = (n <= DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_done = exp_done && csum_ok;
`endif
    send(n16[7:0], rnd ? $urandom_range(gmax, 0) : gmax);
    send(n16[15:8], rnd ? $urandom_range(gmax, 0) : gmax);
    if (n > DEPTH) begin
      check({tag, "_err_lat"}, 32'(error), 32'd1);
      check({tag, "_err_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_err_hold"}, 32'(core_hold), 32'd1);
    end else begin
      for (int unsigned i = 0; i < 4*n; i++)
        send(pay[i], rnd ? $urandom_range(gmax, 0) : gmax);
      if (gmax == 0 && n > 0) begin
        check({tag, "_we_lat"}, 32'(mem_we), 32'd1);
        check({tag, "_we_addr"}, 32'(mem_addr), n - 1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(csum_ok ? x : ~x, 0);
`endif
      if (gmax == 0) check({tag, "_done_lat"}, 32'(done), 32'(exp_done));
    end
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, obs_a.size(), exp_a.size());
    bad = 0;
    for (int unsigned i = 0; i < exp_a.size() && i < obs_a.size(); i++)
      if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i]) bad++;
    check({tag, "_wr_bad"}, bad, 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_hold"}, 32'(core_hold), 32'(!exp_done));
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic set_two_word_payload();
    pay.delete();
    pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
  endtask

  task automatic rand_payload(input int unsigned n);
    pay.delete();
    for (int unsigned i = 0; i < 4*n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b1);

    // Two-word program, back-to-back then with 3-cycle gaps
    set_two_word_payload();
    run_image("two_word", 2, 0, 1'b0, 1'b1);
    check("two_word_d0", obs_d.size() > 0 ? obs_d[0] : 32'hDEAD, 32'h00A00513);
    check("two_word_d1", obs_d.size() > 1 ? obs_d[1] : 32'hDEAD, 32'h00100593);
    do_reset(1'b0);
    run_image("gapped", 2, 3, 1'b0, 1'b1);

    // Empty image, then a trailing byte must be refused
    do_reset(1'b0);
    pay.delete();
    run_image("empty", 0, 0, 1'b0, 1'b1);
    send(8'hA5, 1);
    check("trail_nwr", obs_a.size(), 32'd0);
    check("trail_done", 32'(done), 32'd1);

    // Oversized header
    do_reset(1'b0);
    pay.delete();
    run_image("too_big", DEPTH + 1, 0, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset(1'b0);
    pay = '{8'h13, 8'h05, 8'hA0, 8'h00};
    run_image("csum_bad", 1, 0, 1'b0, 1'b0);
`endif

    // Abort mid-load after 5 payload bytes, then a complete load
    do_reset(1'b0);
    set_two_word_payload();
    send(8'h02, 0);
    send(8'h00, 0);
    for (int unsigned i = 0; i < 5; i++) send(pay[i], 0);
    @(negedge clk);
    check("abort_nwr", obs_a.size(), 32'd1);
    check("abort_addr", obs_a.size() > 0 ? obs_a[0] : 32'hFFFF, 32'd0);
    check("abort_data", obs_d.size() > 0 ? obs_d[0] : 32'hDEAD, 32'h00A00513);
    do_reset(1'b0);
    run_image("after_abort", 2, 0, 1'b0, 1'b1);

    // Randomized images with random gaps
    for (int unsigned k = 0; k < 6; k++) begin
      int unsigned n;
      n = $urandom_range(8, 1);
      do_reset(1'b0);
      rand_payload(n);
      run_image("rand", n, 2, 1'b1, ($urandom_range(3, 0) != 0));
    end

    // Capacity boundary
    do_reset(1'b0);
    rand_payload(DEPTH);
    run_image("full_depth", DEPTH, 0, 1'b0, 1'b1);
    check("full_last_addr", obs_a.size() > 0 ? obs_a[obs_a.size()-1] : 32'hFFFF, DEPTH - 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
